// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller: access size encoding,
// controller FSM states, byte-enable base patterns and an access-legality helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUS  = 2'b01,
    S_RESP = 2'b10
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Accesses that never reach the bus: illegal size or not naturally aligned.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_ILL) ||
           (size == SZ_HALF && off[0]) ||
           (size == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane steering: replicates store data across byte lanes and
// extracts/extends load data from the bus word.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [31:0] wdata,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_data = wdata;
    case (st_size)
      SZ_BYTE: st_data = {4{wdata[7:0]}};
      SZ_HALF: st_data = {2{wdata[15:0]}};
      default: st_data = wdata;
    endcase
  end

  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & shifted[7]}},  shifted[7:0]};
      SZ_HALF: ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns memory-stage load/store requests into single word
// bus cycles. Define DMEM_TIMEOUT_EN to abort bus cycles after TIMEOUT_CYCLES.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [1:0]               i_size,
  input  logic                     i_unsigned,
  input  logic                     i_wr,
  output logic                     o_resp_valid,
  output logic [DATA_WIDTH-1:0]    o_rdata,
  output logic                     o_err,
  output logic                     o_bus_valid,
  output logic [ADDRESS_WIDTH-1:0] o_bus_addr,
  output logic                     o_bus_we,
  output logic [3:0]               o_bus_be,
  output logic [DATA_WIDTH-1:0]    o_bus_wdata,
  input  logic                     i_bus_ack,
  input  logic [DATA_WIDTH-1:0]    i_bus_rdata
);

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dmem_ctrl: DATA_WIDTH must be 32 and TIMEOUT_CYCLES at least 1");
  end

  state_e      state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_unsigned;
  logic        lat_wr;
  logic        bad;
  logic [3:0]  be;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign bad = access_bad(i_size, i_addr[1:0]);

  always_comb begin
    be = BE_WORD;
    case (i_size)
      SZ_BYTE: be = BE_BYTE << i_addr[1:0];
      SZ_HALF: be = BE_HALF << i_addr[1:0];
      default: be = BE_WORD;
    endcase
  end

  dmem_lane u_lane (
    .st_size     (i_size),
    .wdata       (i_wdata),
    .st_data     (st_data),
    .ld_size     (lat_size),
    .ld_unsigned (lat_unsigned),
    .ld_off      (lat_off),
    .rdata       (i_bus_rdata),
    .ld_data     (ld_data)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          timed_out;

  // cnt holds the index of the current BUS cycle; the last permitted one aborts.
  assign timed_out = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            cnt <= '0;
    else if (state == S_BUS) cnt <= cnt + 1'b1;
    else                     cnt <= '0;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_rdata      <= '0;
      o_err        <= 1'b0;
      o_bus_valid  <= 1'b0;
      o_bus_addr   <= '0;
      o_bus_we     <= 1'b0;
      o_bus_be     <= '0;
      o_bus_wdata  <= '0;
      lat_size     <= '0;
      lat_off      <= '0;
      lat_unsigned <= 1'b0;
      lat_wr       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            if (bad) begin
              state        <= S_RESP;
              o_resp_valid <= 1'b1;
              o_err        <= 1'b1;
            end else begin
              state        <= S_BUS;
              o_bus_valid  <= 1'b1;
              o_bus_addr   <= {i_addr[ADDRESS_WIDTH-1:2], 2'b00};
              o_bus_we     <= i_wr;
              o_bus_be     <= be;
              o_bus_wdata  <= st_data;
              lat_size     <= i_size;
              lat_off      <= i_addr[1:0];
              lat_unsigned <= i_unsigned;
              lat_wr       <= i_wr;
            end
          end
        end
        S_BUS: begin
          if (i_bus_ack) begin
            state        <= S_RESP;
            o_bus_valid  <= 1'b0;
            o_resp_valid <= 1'b1;
            o_err        <= 1'b0;
            o_rdata      <= lat_wr ? '0 : ld_data;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (timed_out) begin
            state        <= S_RESP;
            o_bus_valid  <= 1'b0;
            o_resp_valid <= 1'b1;
            o_err        <= 1'b1;
            o_rdata      <= '0;
          end
`endif
        end
        default: begin
          state        <= S_IDLE;
          o_req_ready  <= 1'b1;
          o_resp_valid <= 1'b0;
          o_err        <= 1'b0;
          o_rdata      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed corner cases plus random traffic checked
// against a byte-level reference model; honours DMEM_TIMEOUT_EN when defined.
module tb_dmem_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, unsgn, wr;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        resp_valid, err, bus_valid, bus_we, bus_ack;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_addr(addr), .i_wdata(wdata), .i_size(size), .i_unsigned(unsgn), .i_wr(wr),
    .o_resp_valid(resp_valid), .o_rdata(rdata), .o_err(err),
    .o_bus_valid(bus_valid), .o_bus_addr(bus_addr), .o_bus_we(bus_we), .o_bus_be(bus_be),
    .o_bus_wdata(bus_wdata), .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata)
  );

  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_t;

  resp_t       rq[$];
  bus_t        bq[$];
  resp_t       mon_e;
  bus_t        cur;
  int          compared = 0, mismatched = 0;
  int          cyc = 0, n_resp = 0, bus_cnt = 0;
  int          ack_delay = 0;
  logic [31:0] ack_rdata = '0;
  logic        stray_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Response monitor: every completion pops one expectation.
  always @(negedge clk) begin
    cyc++;
    if (resp_valid) begin
      n_resp++;
      if (rq.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
      else begin
        mon_e = rq.pop_front();
        check("resp_rdata", rdata, mon_e.rdata);
        check("resp_err", {31'd0, err}, {31'd0, mon_e.err});
        check("resp_latency", cyc, mon_e.cyc);
      end
    end
  end

  // Bus responder: acks in BUS cycle ack_delay (0 = first), sprays stray acks when idle.
  always @(negedge clk) begin
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    if (!bus_valid) begin
      bus_cnt = 0;
      if (stray_en && $urandom_range(0, 3) == 0) bus_ack = 1'b1;
    end else begin
      if (bus_cnt == 0) begin
        if (bq.size() == 0) check("unexpected_bus", 32'd1, 32'd0);
        else begin
          cur = bq.pop_front();
          check("bus_addr", bus_addr, cur.addr);
          check("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
          check("bus_be", {28'd0, bus_be}, {28'd0, cur.be});
          check("bus_wdata", bus_wdata, cur.wdata);
        end
      end else begin
        check("bus_hold", {31'd0, (bus_addr !== cur.addr) || (bus_be !== cur.be) ||
                                  (bus_we !== cur.we) || (bus_wdata !== cur.wdata)}, 32'd0);
      end
      if (bus_cnt == ack_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = ack_rdata;
      end
      bus_cnt++;
    end
  end

  // One access; reference model works on byte lanes and natural alignment.
  task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                        input logic w, input logic [31:0] wd, input int d,
                        input logic [31:0] rd, input bit abort);
    resp_t e;
    bus_t  b;
    logic  bad, timed;
    int    n, off, start;
    logic [31:0] v;
    n     = 1 << sz;
    off   = int'(a[1:0]);
    bad   = (sz == 2'd3) || (a % n != 0);
    timed = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    timed = (d >= TO);
`endif
    ack_delay = d;
    ack_rdata = rd;
    if (!bad) begin
      b.addr = a & ~32'h3; b.we = w; b.be = '0; b.wdata = '0;
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + n) b.be[i] = 1'b1;
        b.wdata[i*8 +: 8] = wd[(i % n)*8 +: 8];
      end
      bq.push_back(b);
    end
    v = '0;
    if (!bad && !w && !timed) begin
      for (int i = 0; i < n; i++) v[i*8 +: 8] = rd[(off + i)*8 +: 8];
      if (!uns && n < 4 && v[n*8-1]) for (int i = n*8; i < 32; i++) v[i] = 1'b1;
    end
    e.rdata = v;
    e.err   = bad || timed;
    @(negedge clk); #1;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    e.cyc = cyc + (bad ? 1 : (timed ? 1 + TO : 2 + d));
    if (!abort) rq.push_back(e);
    addr = a; size = sz; unsgn = uns; wr = w; wdata = wd; req_valid = 1'b1;
    if (abort) begin
      repeat (3) begin @(negedge clk); #1; end
      check("bus_before_rst", {31'd0, bus_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
      check("rst_outputs", {bus_addr | bus_wdata | rdata} | {26'd0, resp_valid, err, bus_we, bus_be[2:0] | {2'b0, bus_be[3]}}, 32'd0);
      req_valid = 1'b0;
      bq.delete();
      repeat (3) begin @(negedge clk); #1; end
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    end else begin
      start = n_resp;
      for (int k = 0; k < 150 && n_resp == start; k++) begin @(negedge clk); #1; end
      if (n_resp == start) begin
        check("resp_timeout", 32'd0, 32'd1);
        rq.delete(); bq.delete();
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      addr = $urandom; wdata = $urandom;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; addr = '0; wdata = '0; size = '0; unsgn = 1'b0; wr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {bus_addr | bus_wdata | rdata} | {26'd0, resp_valid, err, bus_valid, bus_we, 2'b0}, 32'd0);
    check("reset_be", {28'd0, bus_be}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_ready", {31'd0, req_ready}, 32'd1);

    do_req(32'h100, 2'd2, 1'b0, 1'b0, 32'h0,        0, 32'hDEADBEEF, 1'b0);
    do_req(32'h103, 2'd0, 1'b0, 1'b0, 32'h0,        0, 32'h80FFFFFF, 1'b0);
    do_req(32'h103, 2'd0, 1'b1, 1'b0, 32'h0,        0, 32'h80FFFFFF, 1'b0);
    do_req(32'h102, 2'd1, 1'b0, 1'b1, 32'h1234ABCD, 0, 32'h0,        1'b0);
    do_req(32'h102, 2'd1, 1'b0, 1'b0, 32'h0,        1, 32'h8001FFFF, 1'b0);
    do_req(32'h101, 2'd2, 1'b0, 1'b0, 32'h0,        0, 32'h0,        1'b0);
    do_req(32'h100, 2'd3, 1'b0, 1'b0, 32'h0,        0, 32'h0,        1'b0);
    do_req(32'h103, 2'd1, 1'b1, 1'b1, 32'h55AA55AA, 0, 32'h0,        1'b0);
    do_req(32'h200, 2'd2, 1'b0, 1'b0, 32'h0,       40, 32'hCAFEF00D, 1'b0);
    do_req(32'h204, 2'd2, 1'b0, 1'b0, 32'h0,       TO-1, 32'h0BADC0DE, 1'b0);
    do_req(32'h300, 2'd2, 1'b0, 1'b1, 32'h11223344, 10, 32'h0,       1'b1);
    do_req(32'h304, 2'd2, 1'b0, 1'b0, 32'h0,        0, 32'h76543210, 1'b0);

    stray_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      do_req({$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom,
             ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3)),
             $urandom, 1'b0);
    end
    stray_en = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("queues_drained", rq.size() + bq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
